bus_timer: RTL
==============

Name: bus_timer

Overview:
- Memory-mapped timer peripheral that responds to the CPU's 32-bit load/store bus.
- Decodes its own 16-byte window and exposes CTRL, COUNT, COMPARE and STATUS registers.
- Runs a prescaled 32-bit up-counter with compare match, one-shot or auto-reload mode, and a sticky interrupt flag.
- Sits on the shared system bus beside RAM/ROM. Its read data is zero when not selected, so responders can be OR-combined.

Parameters:
- BASE_ADDRESS, 32'hF000_0000, base of the 16-byte register window; bits [3:0] must be zero.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- busAddress  input  32  byte address driven by the CPU
- busDataIn  input  32  write data from the CPU (the CPU's dataOut)
- busDataOut  output  32  read data to the CPU (OR-combined into the CPU's dataIn)
- busWriteEnable  input  1  1 => WRITE, 0 => READ
- irq  output  1  level interrupt; equals STATUS.match

Behaviour:
- One clock (clk); reset is synchronous and active-high. All state updates on the rising edge of clk.
- Select: sel = (busAddress[31:4] == BASE_ADDRESS[31:4]). Register index = busAddress[3:2]; busAddress[1:0] ignored.
- Register map:
  - 0x0 CTRL: [0] enable, [1] autoReload, [15:8] prescale; other bits read 0.
  - 0x4 COUNT: current count.
  - 0x8 COMPARE.
  - 0xC STATUS: [0] match; write 1 to clear, write 0 no effect.
- Reset values: CTRL=0, COUNT=0, COMPARE=32'hFFFF_FFFF, STATUS=0, prescale counter=0, busDataOut=0, irq=0.
- Write: on an edge with sel && busWriteEnable, the indexed register is updated from busDataIn.
- Read: busDataOut is registered.
  - On each edge: busDataOut <= (sel && !busWriteEnable) ? reg[index] : 0.
  - Latency is 1 cycle. The value returned is the register as it stood before that edge's updates.
  - A write cycle returns 0 on the following cycle.
- Prescaler:
  - While enable=1, an 8-bit prescale counter increments each cycle.
  - tick asserts when the prescale counter == prescale; the prescale counter then returns to 0.
  - prescale=0 gives a tick every cycle.
  - While enable=0, the prescale counter holds at 0 and no ticks occur.
  - Any write to CTRL clears the prescale counter.
- Counter, on tick:
  - If COUNT == COMPARE: set STATUS.match. If autoReload=1, COUNT <= 0. If autoReload=0, COUNT holds and CTRL.enable <= 0 (one-shot stop).
  - Otherwise COUNT <= COUNT + 1, wrapping 32'hFFFF_FFFF -> 0 with no flag.
- Simultaneous events:
  - CPU write to COUNT in the same cycle as tick: the write wins.
  - CPU write to CTRL in the same cycle as a one-shot match: the written enable value wins.
  - Write-1-to-clear on STATUS in the same cycle as a new match: the flag stays set.
- Compare uses the pre-edge COUNT and COMPARE values.
- irq = STATUS.match, a registered level. The CPU clears it only through STATUS.
- Reset asserted mid-count returns everything to reset values on that edge. No tick or write is processed in a reset cycle.

Test Plan:
- Reset check: hold reset 2 cycles, then read 0x0/0x4/0x8/0xC -> 0, 0, 32'hFFFF_FFFF, 0; irq=0.
- Read latency and decode:
  - Write COMPARE=32'h1234, then read 0xF000_0008 -> busDataOut=32'h1234 exactly one cycle later.
  - Read 0xF000_0010 (outside the window) -> busDataOut=0.
- Auto-reload at full speed:
  - Set COMPARE=3, CTRL=32'h3 (prescale 0).
  - COUNT reaches 3 after 3 ticks; the match tick reloads 0 and sets irq.
  - Flag persists across further matches.
  - Write STATUS=1 -> irq=0 next cycle.
- Prescaler:
  - CTRL=32'h0000_0201 (prescale 2, one-shot), COMPARE=2.
  - COUNT increments every 3rd cycle.
  - On the match tick (9th tick-cycle from enable), irq=1, enable reads 0, COUNT holds at 2.
- Collisions:
  - Write COUNT=100 on a tick cycle -> COUNT reads 100, not old+1.
  - Write STATUS=1 on a match cycle -> irq stays 1.
- Wrap and reset:
  - COUNT=32'hFFFF_FFFF, COMPARE=5, prescale 0, enabled -> next COUNT=0 with no flag.
  - Assert reset mid-count -> all registers return to reset values on that edge.

Source files
------------

// File: rtl/bus_timer.sv
// Memory-mapped 32-bit timer: prescaled up-counter with compare match,
// one-shot or auto-reload mode, and a sticky match flag driving irq.
module bus_timer #(
  parameter logic [31:0] BASE_ADDRESS = 32'hF000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] busAddress,
  input  logic [31:0] busDataIn,
  output logic [31:0] busDataOut,
  input  logic        busWriteEnable,
  output logic        irq
);

  // Bus protocol: every cycle with the window selected is a complete
  // transaction (no wait states). A write commits on that edge; a read
  // returns the pre-edge register value on busDataOut one cycle later.
  // busDataOut is 0 whenever the previous cycle was not a read of this
  // window, so responders can be OR-combined.

  localparam logic [1:0] IDX_CTRL    = 2'd0;
  localparam logic [1:0] IDX_COUNT   = 2'd1;
  localparam logic [1:0] IDX_COMPARE = 2'd2;
  localparam logic [1:0] IDX_STATUS  = 2'd3;

  logic        sel;
  logic [1:0]  regIndex;
  logic        wrCtrl;
  logic        wrCount;
  logic        wrCompare;
  logic        wrStatus;

  logic        ctrlEnable;
  logic        ctrlAutoReload;
  logic [7:0]  ctrlPrescale;
  logic [7:0]  preCount;
  logic [31:0] count;
  logic [31:0] compare;
  logic        statusMatch;

  logic        tick;
  logic        isMatch;
  logic        matchEvent;
  logic [31:0] readMux;

  logic        unusedBits;
  assign unusedBits = &{1'b0, busAddress[1:0]};

  assign sel      = (busAddress[31:4] == BASE_ADDRESS[31:4]);
  assign regIndex = busAddress[3:2];

  assign wrCtrl    = sel && busWriteEnable && (regIndex == IDX_CTRL);
  assign wrCount   = sel && busWriteEnable && (regIndex == IDX_COUNT);
  assign wrCompare = sel && busWriteEnable && (regIndex == IDX_COMPARE);
  assign wrStatus  = sel && busWriteEnable && (regIndex == IDX_STATUS);

  assign tick       = ctrlEnable && (preCount == ctrlPrescale);
  assign isMatch    = (count == compare);
  assign matchEvent = tick && isMatch;

  always_comb begin
    readMux = 32'd0;
    case (regIndex)
      IDX_CTRL:    readMux = {16'd0, ctrlPrescale, 6'd0, ctrlAutoReload, ctrlEnable};
      IDX_COUNT:   readMux = count;
      IDX_COMPARE: readMux = compare;
      IDX_STATUS:  readMux = {31'd0, statusMatch};
      default:     readMux = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrlEnable     <= 1'b0;
      ctrlAutoReload <= 1'b0;
      ctrlPrescale   <= 8'd0;
      preCount       <= 8'd0;
      count          <= 32'd0;
      compare        <= 32'hFFFF_FFFF;
      statusMatch    <= 1'b0;
      busDataOut     <= 32'd0;
    end else begin
      busDataOut <= (sel && !busWriteEnable) ? readMux : 32'd0;

      // Prescale counter restarts on any CTRL write so a new rate takes
      // effect with a full first period.
      if (wrCtrl || !ctrlEnable || tick) begin
        preCount <= 8'd0;
      end else begin
        preCount <= preCount + 8'd1;
      end

      if (wrCtrl) begin
        ctrlEnable     <= busDataIn[0];
        ctrlAutoReload <= busDataIn[1];
        ctrlPrescale   <= busDataIn[15:8];
      end else if (matchEvent && !ctrlAutoReload) begin
        ctrlEnable <= 1'b0;
      end

      // CPU write to COUNT overrides whatever the tick would have done.
      if (wrCount) begin
        count <= busDataIn;
      end else if (tick) begin
        if (!isMatch) begin
          count <= count + 32'd1;
        end else if (ctrlAutoReload) begin
          count <= 32'd0;
        end
      end

      if (wrCompare) begin
        compare <= busDataIn;
      end

      // A new match beats a simultaneous write-1-to-clear.
      if (matchEvent) begin
        statusMatch <= 1'b1;
      end else if (wrStatus && busDataIn[0]) begin
        statusMatch <= 1'b0;
      end
    end
  end

  assign irq = statusMatch;

endmodule
